// File: rtl/branch_predict_unit.sv
// Zero-latency fetch predictor: direct-mapped BTB plus a 2-bit counter BHT
// indexed by PC (bimodal) or PC^history (gshare), with speculative global history.
module branch_predict_unit #(
    parameter int BTB_ENTRIES = 16,
    parameter int BHT_ENTRIES = 64,
    parameter int GHR_WIDTH   = 6,
    parameter int MODE        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_is_branch,
    input  logic                 upd_is_jump,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic [GHR_WIDTH-1:0] upd_ghr,
    input  logic                 upd_mispredict,
    output logic [31:0]          mispredict_cnt
);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int TAG_W  = 30 - BTB_IW;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             jump;
    } btb_entry_t;

    btb_entry_t           btb [BTB_ENTRIES];
    logic [1:0]           bht [BHT_ENTRIES];
    logic [GHR_WIDTH-1:0] ghr;

    function automatic logic [BHT_IW-1:0] bht_index(input logic [31:0] pc,
                                                    input logic [GHR_WIDTH-1:0] h);
        logic [BHT_IW-1:0] idx;
        idx = pc[BHT_IW+1:2];
        if (MODE == 1) idx = idx ^ BHT_IW'(h);
        return idx;
    endfunction

    // Concatenate-then-truncate keeps the shift legal for GHR_WIDTH == 1.
    function automatic logic [GHR_WIDTH-1:0] shift_hist(input logic [GHR_WIDTH-1:0] h,
                                                        input logic b);
        logic [GHR_WIDTH:0] t;
        t = {h, b};
        return t[GHR_WIDTH-1:0];
    endfunction

    logic              unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    // Fetch side
    btb_entry_t  f_ent;
    logic [1:0]  f_ctr;

    always_comb begin
        f_ent       = btb[fetch_pc[BTB_IW+1:2]];
        f_ctr       = bht[bht_index(fetch_pc, ghr)];
        pred_hit    = f_ent.valid && (f_ent.tag == fetch_pc[31:BTB_IW+2]);
        pred_taken  = pred_hit && (f_ent.jump || f_ctr[1]);
        pred_target = pred_taken ? f_ent.target : fetch_pc + 32'd4;
        pred_ghr    = ghr;
    end

    // Update side; a branch+jump encoding behaves as a jump
    logic             u_br;
    logic             u_alloc;
    logic [BHT_IW-1:0] u_bht_idx;

    always_comb begin
        u_br      = upd_is_branch && !upd_is_jump;
        u_alloc   = upd_valid && (upd_is_jump || (u_br && upd_taken));
        u_bht_idx = bht_index(upd_pc, upd_ghr);
    end

    always_ff @(posedge clk) begin
        if (rst)
            ghr <= '0;
        else if (upd_valid && upd_mispredict && upd_is_jump)
            ghr <= upd_ghr;
        else if (upd_valid && upd_mispredict && u_br)
            ghr <= shift_hist(upd_ghr, upd_taken);
        else if (fetch_valid && pred_hit && !f_ent.jump)
            ghr <= shift_hist(ghr, pred_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
        end else if (u_alloc) begin
            btb[upd_pc[BTB_IW+1:2]] <= {1'b1, upd_pc[31:BTB_IW+2], upd_target, upd_is_jump};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (upd_valid && u_br) begin
            if (upd_taken && bht[u_bht_idx] != 2'b11)
                bht[u_bht_idx] <= bht[u_bht_idx] + 2'b01;
            else if (!upd_taken && bht[u_bht_idx] != 2'b00)
                bht[u_bht_idx] <= bht[u_bht_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            mispredict_cnt <= '0;
        else if (upd_valid && upd_mispredict && mispredict_cnt != 32'hFFFF_FFFF)
            mispredict_cnt <= mispredict_cnt + 32'd1;
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: a vector table drives a bimodal instance, hand sequences
// cover gshare history recovery and counter saturation.
module tb_branch_predict_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // bimodal instance
    logic        rst0, fv0, uv0, ubr0, ujmp0, utk0, ump0;
    logic [31:0] fpc0, upc0, utgt0;
    logic [5:0]  ughr0;
    logic        hit0, tk0;
    logic [31:0] tgt0, cnt0;
    logic [5:0]  ghr0;

    branch_predict_unit #(.BTB_ENTRIES(16), .BHT_ENTRIES(64), .GHR_WIDTH(6), .MODE(0)) u0 (
        .clk(clk), .rst(rst0), .fetch_valid(fv0), .fetch_pc(fpc0),
        .pred_hit(hit0), .pred_taken(tk0), .pred_target(tgt0), .pred_ghr(ghr0),
        .upd_valid(uv0), .upd_pc(upc0), .upd_is_branch(ubr0), .upd_is_jump(ujmp0),
        .upd_taken(utk0), .upd_target(utgt0), .upd_ghr(ughr0), .upd_mispredict(ump0),
        .mispredict_cnt(cnt0));

    // gshare instance
    logic        rst1, fv1, uv1, ubr1, ujmp1, utk1, ump1;
    logic [31:0] fpc1, upc1, utgt1;
    logic [5:0]  ughr1;
    logic        hit1, tk1;
    logic [31:0] tgt1, cnt1;
    logic [5:0]  ghr1;

    branch_predict_unit #(.BTB_ENTRIES(16), .BHT_ENTRIES(64), .GHR_WIDTH(6), .MODE(1)) u1 (
        .clk(clk), .rst(rst1), .fetch_valid(fv1), .fetch_pc(fpc1),
        .pred_hit(hit1), .pred_taken(tk1), .pred_target(tgt1), .pred_ghr(ghr1),
        .upd_valid(uv1), .upd_pc(upc1), .upd_is_branch(ubr1), .upd_is_jump(ujmp1),
        .upd_taken(utk1), .upd_target(utgt1), .upd_ghr(ughr1), .upd_mispredict(ump1),
        .mispredict_cnt(cnt1));

    typedef struct {
        logic        rst, fv;
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ubr, ujmp, utk;
        logic [31:0] utgt;
        logic [5:0]  ughr;
        logic        ump;
        logic        chk, hit, tk;
        logic [31:0] tgt;
        logic [5:0]  ghr;
        logic [31:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic fv, input logic [31:0] fpc,
                       input logic uv, input logic [31:0] upc, input logic ubr,
                       input logic ujmp, input logic utk, input logic [31:0] utgt,
                       input logic [5:0] ughr, input logic ump,
                       input logic chk, input logic hit, input logic tk,
                       input logic [31:0] tgt, input logic [5:0] ghr, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.fv = fv; v.fpc = fpc; v.uv = uv; v.upc = upc; v.ubr = ubr;
        v.ujmp = ujmp; v.utk = utk; v.utgt = utgt; v.ughr = ughr; v.ump = ump;
        v.chk = chk; v.hit = hit; v.tk = tk; v.tgt = tgt; v.ghr = ghr; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic fv, input logic [31:0] fpc, input logic uv,
                          input logic [31:0] upc, input logic ubr, input logic ujmp,
                          input logic utk, input logic [31:0] utgt,
                          input logic [5:0] ughr, input logic ump);
        fv1 = fv; fpc1 = fpc; uv1 = uv; upc1 = upc; ubr1 = ubr; ujmp1 = ujmp;
        utk1 = utk; utgt1 = utgt; ughr1 = ughr; ump1 = ump;
    endtask

    initial begin
        rst0 = 1; fv0 = 0; fpc0 = 0; uv0 = 0; upc0 = 0; ubr0 = 0; ujmp0 = 0;
        utk0 = 0; utgt0 = 0; ughr0 = 0; ump0 = 0;
        rst1 = 1; drive1(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //  rst fv fpc          uv upc    br jp tk tgt     ughr ump  chk hit tk tgt         ghr cnt
        add(1, 1, 32'h60,       0, 0,     0, 0, 0, 0,       0,  0,   0, 0, 0, 0,          0,  0);
        add(0, 0, 32'h60,       0, 0,     0, 0, 0, 0,       0,  0,   1, 0, 0, 32'h64,     0,  0);
        add(0, 1, 32'h100,      1, 32'h100, 1, 0, 1, 32'h80, 0,  1,   1, 0, 0, 32'h104,    0,  0);
        add(0, 0, 32'h100,      0, 0,     0, 0, 0, 0,       0,  0,   1, 1, 1, 32'h80,     1,  1);
        for (int k = 0; k < 4; k++)
            add(0, 0, 32'h100,  1, 32'h100, 1, 0, 1, 32'h80, 1,  0,   1, 1, 1, 32'h80,     1,  1);
        add(0, 0, 32'h100,      1, 32'h100, 1, 0, 0, 32'h80, 1,  0,   1, 1, 1, 32'h80,     1,  1);
        add(0, 0, 32'h100,      1, 32'h100, 1, 0, 0, 32'h80, 1,  0,   1, 1, 1, 32'h80,     1,  1);
        add(0, 0, 32'h100,      1, 32'h100, 1, 0, 0, 32'h80, 1,  0,   1, 1, 0, 32'h104,    1,  1);
        add(0, 0, 32'h100,      1, 32'h100, 1, 0, 0, 32'h80, 1,  0,   1, 1, 0, 32'h104,    1,  1);
        add(0, 0, 32'h100,      0, 0,     0, 0, 0, 0,       0,  0,   1, 1, 0, 32'h104,    1,  1);
        // jump overwrites the aliased entry; fetch of a jump leaves history alone
        add(0, 0, 32'h200,      1, 32'h200, 0, 1, 1, 32'h1000, 1, 1,  1, 0, 0, 32'h204,    1,  1);
        add(0, 1, 32'h200,      0, 0,     0, 0, 0, 0,       0,  0,   1, 1, 1, 32'h1000,   1,  2);
        add(0, 0, 32'h100,      0, 0,     0, 0, 0, 0,       0,  0,   1, 0, 0, 32'h104,    1,  2);
        add(0, 0, 32'h40,       1, 32'h40, 1, 0, 1, 32'h400, 1,  0,   1, 0, 0, 32'h44,     1,  2);
        add(0, 0, 32'h40,       1, 32'h80, 1, 0, 1, 32'h800, 1,  0,   1, 1, 1, 32'h400,    1,  2);
        add(0, 0, 32'h40,       0, 0,     0, 0, 0, 0,       0,  0,   1, 0, 0, 32'h44,     1,  2);
        add(0, 0, 32'h80,       0, 0,     0, 0, 0, 0,       0,  0,   1, 1, 1, 32'h800,    1,  2);
        add(0, 0, 32'h80,       1, 32'h80, 1, 0, 0, 0,       1,  1,   1, 1, 1, 32'h800,    1,  2);
        add(0, 0, 32'h80,       0, 0,     0, 0, 0, 0,       0,  0,   1, 1, 0, 32'h84,     2,  3);
        // PC wrap, plus a branch+jump update that must not touch the counter
        add(0, 0, 32'hFFFFFFFC, 1, 32'h300, 1, 1, 1, 32'h3000, 0, 0,  1, 0, 0, 32'h0,      2,  3);
        add(0, 0, 32'h300,      0, 0,     0, 0, 0, 0,       0,  0,   1, 1, 1, 32'h3000,   2,  3);
        add(0, 0, 32'h300,      1, 32'h100, 1, 0, 1, 32'h80, 0,  0,   1, 1, 1, 32'h3000,   2,  3);
        add(0, 0, 32'h100,      0, 0,     0, 0, 0, 0,       0,  0,   1, 1, 0, 32'h104,    2,  3);
        // mid-run reset with a discarded update
        add(1, 1, 32'h100,      1, 32'h100, 1, 0, 1, 32'h80, 1,  1,   0, 0, 0, 0,          0,  0);
        add(0, 0, 32'h80,       0, 0,     0, 0, 0, 0,       0,  0,   1, 0, 0, 32'h84,     0,  0);
        add(0, 0, 32'h40,       1, 32'h40, 1, 0, 1, 32'h400, 0,  0,   1, 0, 0, 32'h44,     0,  0);
        add(0, 0, 32'h40,       1, 32'h40, 1, 0, 0, 0,       0,  0,   1, 1, 1, 32'h400,    0,  0);
        add(0, 0, 32'h40,       0, 0,     0, 0, 0, 0,       0,  0,   1, 1, 0, 32'h44,     0,  0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst0 = vq[i].rst; fv0 = vq[i].fv; fpc0 = vq[i].fpc; uv0 = vq[i].uv;
            upc0 = vq[i].upc; ubr0 = vq[i].ubr; ujmp0 = vq[i].ujmp; utk0 = vq[i].utk;
            utgt0 = vq[i].utgt; ughr0 = vq[i].ughr; ump0 = vq[i].ump;
            #1;
            if (vq[i].chk) begin
                check($sformatf("row%0d hit", i), {31'd0, hit0}, {31'd0, vq[i].hit});
                check($sformatf("row%0d taken", i), {31'd0, tk0}, {31'd0, vq[i].tk});
                check($sformatf("row%0d target", i), tgt0, vq[i].tgt);
                check($sformatf("row%0d ghr", i), {26'd0, ghr0}, {26'd0, vq[i].ghr});
                check($sformatf("row%0d cnt", i), cnt0, vq[i].cnt);
            end
        end

        // counter saturation: preload just below the top, then two mispredicts
        @(negedge clk);
        fv0 = 0; ubr0 = 0; ujmp0 = 0; utk0 = 0; uv0 = 1; ump0 = 1;
        force u0.mispredict_cnt = 32'hFFFF_FFFE;
        #1 release u0.mispredict_cnt;
        @(negedge clk); #1;
        check("cnt reaches max", cnt0, 32'hFFFF_FFFF);
        @(negedge clk); uv0 = 0; ump0 = 0; #1;
        check("cnt saturates", cnt0, 32'hFFFF_FFFF);

        // gshare: recovery beats a same-cycle speculative shift
        @(negedge clk); rst1 = 1;
        @(negedge clk); rst1 = 0;
        drive1(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 6'b000000, 0);
        #1 check("g reset ghr", {26'd0, ghr1}, 32'd0);
        @(negedge clk);
        drive1(0, 32'h100, 1, 32'h504, 1, 0, 1, 32'h900, 6'b000010, 1);
        @(negedge clk);
        drive1(1, 32'h100, 1, 32'h504, 1, 0, 1, 32'h900, 6'b110011, 1);
        #1;
        check("g ghr before", {26'd0, ghr1}, 32'b000101);
        check("g hit", {31'd0, hit1}, 32'd1);
        check("g xor index taken", {31'd0, tk1}, 32'd0);
        check("g target", tgt1, 32'h104);
        @(negedge clk);
        drive1(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("g recovered ghr", {26'd0, ghr1}, 32'b100111);
        check("g taken2", {31'd0, tk1}, 32'd0);
        check("g cnt", cnt1, 32'd2);
        @(negedge clk);
        drive1(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("g spec shift", {26'd0, ghr1}, 32'b001110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
